// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin arbiter that shares one AHB-Lite address/data path
// among NUM_MASTERS masters. A grant is never moved in the middle of a
// fixed-length burst or a locked sequence. With no requests pending, the bus
// parks on master 0.
//
// Ports
//   hclk       bus clock, rising edge
//   hreset     asynchronous active-high reset
//   hbusreq    per-master bus request
//   hlock      per-master locked-transfer request
//   htrans     muxed transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ)
//   hburst     muxed burst type
//   hready     muxed bus ready
//   hgrant     one-hot grant, registered
//   hmaster    owner of the current address phase, registered
//   hmastlock  current address-phase transfer is locked, registered
module ahb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = 2
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic                   hmastlock
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;

  typedef enum logic [1:0] {PARK, OWNED, BURST, LOCKED} state_e;

  state_e                   state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [MW-1:0]            master_q, master_d;
  logic                     mastlock_q, mastlock_d;
  logic [MW-1:0]            ptr_q, ptr_d;
  logic [4:0]               cnt_q, cnt_d;

  logic [MW-1:0]            grant_idx;
  logic [MW-1:0]            win_idx;
  logic [MW-1:0]            cand;
  logic                     found;
  logic                     any_req;
  logic [4:0]               len_m1;
  logic                     arb_ok;

  always_comb begin
    // Binary index of the current one-hot grant.
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (grant_q[i]) grant_idx = MW'(i);

    // Round-robin search starting just after the last winner; the last
    // winner itself is checked last so it is reselected only when alone.
    any_req = |hbusreq;
    win_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = MW'((int'(ptr_q) + i) % NUM_MASTERS);
      if (!found && hbusreq[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end

    // Beats remaining after the NONSEQ; INCR is open-ended so treat as 0.
    case (hburst)
      3'b000, 3'b001: len_m1 = 5'd0;
      3'b010, 3'b011: len_m1 = 5'd3;
      3'b100, 3'b101: len_m1 = 5'd7;
      default:        len_m1 = 5'd15;
    endcase

    // Arbitration point: owner not locked, not BUSY, and at a transfer
    // boundary the owner cannot be interrupted across.
    arb_ok = 1'b0;
    if (hready && !hlock[master_q] && htrans != BUSY)
      arb_ok = (htrans == IDLE)
            || (htrans == NONSEQ && hburst == SINGLE)
            || (htrans == SEQ && cnt_q == 5'd1)
            || (hburst == INCR && !hbusreq[master_q]);

    cnt_d = cnt_q;
    if (hready) begin
      if (htrans == NONSEQ)   cnt_d = len_m1;
      else if (htrans == SEQ) cnt_d = (cnt_q == 5'd0) ? 5'd0 : cnt_q - 5'd1;
    end

    grant_d    = grant_q;
    ptr_d      = ptr_q;
    master_d   = master_q;
    mastlock_d = mastlock_q;
    state_d    = state_q;
    if (hready) begin
      master_d   = grant_idx;
      mastlock_d = hlock[grant_idx];
      if (arb_ok) begin
        if (any_req) begin
          grant_d = NUM_MASTERS'(1) << win_idx;
          ptr_d   = win_idx;
          state_d = hlock[win_idx] ? LOCKED : OWNED;
        end else begin
          grant_d = NUM_MASTERS'(1);
          ptr_d   = '0;
          state_d = PARK;
        end
      end else begin
        state_d = hlock[master_q] ? LOCKED : BURST;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= PARK;
      grant_q    <= NUM_MASTERS'(1);
      master_q   <= '0;
      mastlock_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      master_q   <= master_d;
      mastlock_q <= mastlock_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      assert ($onehot(grant_q));
      if (state_q == PARK) assert (grant_q == NUM_MASTERS'(1));
    end
  end

  assign hgrant    = grant_q;
  assign hmaster   = master_q;
  assign hmastlock = mastlock_q;

endmodule
